icache_nway: RTL and testbench
==============================

ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter NSETS, default 8, number of sets, power of two, 2..64.
REQ-002 SHALL have parameter NWAYS, default 2, associativity, 1 or 2 only.
REQ-003 SHALL have parameter WORD_W, default 32, instruction and address width.
REQ-004 SHALL have port CLK  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imemREN  in  1  datapath instruction fetch request.
REQ-007 SHALL have port imemaddr  in  WORD_W  datapath fetch address.
REQ-008 SHALL have port dmemREN/dmemWEN  in  1 each  datapath data access in progress; suppresses ihit.
REQ-009 SHALL have port flush  in  1  invalidate all lines.
REQ-010 SHALL have port ihit  out  1  imemload valid this cycle.
REQ-011 SHALL have port imemload  out  WORD_W  fetched instruction.
REQ-012 SHALL have port iREN  out  1  memory read request.
REQ-013 SHALL have port iaddr  out  WORD_W  memory read address, word-aligned.
REQ-014 SHALL have ports iwait  in  1 (memory busy) and iload  in  WORD_W (memory read data).
REQ-015 SHALL have ports hit_count and miss_count  out  32 each  saturating performance counters.

Function
REQ-016 SHALL split addresses as bytoff = bits [1:0], idx = next log2(NSETS) bits, tag = remaining upper bits.
REQ-017 SHALL store per way per set: valid, tag, one data word; SHALL store per set one LRU bit (unused when NWAYS=1).
REQ-018 SHALL assert ihit combinationally when imemREN=1, dmemREN=0, dmemWEN=0, state=IDLE and any way at idx is valid with a matching tag.
REQ-019 SHALL drive imemload with the matching way's data on a hit; otherwise it is don't-care, with no X-propagation into state.
REQ-020 SHALL use two states, IDLE and FILL.
REQ-021 In IDLE, SHALL treat imemREN=1, no data access, and no hit as a miss: register imemaddr with bytoff cleared as miss_addr, then go to FILL.
REQ-022 In FILL, SHALL hold iREN=1 and iaddr=miss_addr every cycle; iREN SHALL be 0 in IDLE.
REQ-023 In FILL with iwait=0, SHALL write iload, tag(miss_addr) and valid=1 into the victim way at idx(miss_addr), then return to IDLE.
REQ-024 SHALL make the fill observable as ihit on the next cycle if imemaddr is unchanged, giving miss latency = memory latency + 1 cycle.
REQ-025 SHALL use imemaddr changes during FILL only after return to IDLE; the fill always uses miss_addr.
REQ-026 SHALL choose the victim as the lowest-numbered invalid way, else the way indicated by LRU.
REQ-027 SHALL set LRU to the way not used on every hit and every fill completion.
REQ-028 On flush=1, SHALL clear all valid bits in one cycle; in FILL it SHALL abort the fill (no line write, iREN=0 next cycle) and enter IDLE; ihit SHALL be 0 during the flush cycle.
REQ-029 SHALL increment hit_count once per cycle with ihit=1, and miss_count once per IDLE->FILL transition; both SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-030 On nRST=0, SHALL immediately enter state IDLE and clear all valid bits, LRU bits and both counters; ihit=0, iREN=0, iaddr=0.
REQ-031 Reset during FILL SHALL discard the pending fill with no line written; tag and data arrays need not be reset.

Structure
REQ-032 SHALL place icache_state_t (IDLE, FILL) and the WORD_W-derived bytoff width constant in cpu_types_pkg; set-dependent widths are computed locally from parameters.
REQ-033 SHALL have one sub-module, icache_way (valid/tag/data arrays, tag compare, write port), instantiated NWAYS times.

Verification
REQ-034 Cold miss: NSETS=8, NWAYS=2, fetch 0x00000040, iwait=1 for 3 cycles -> iREN=1 and iaddr=0x40 for 4 cycles, ihit the next cycle, miss_count=1.
REQ-035 Conflict: fetch 0x00, 0x20, 0x00, then 0x40 (all idx 0) -> 3 misses; 0x40 evicts 0x20 (LRU); refetch 0x00 hits, 0x20 misses.
REQ-036 NWAYS=1: fetch 0x00 then 0x20 then 0x00 -> every access misses, miss_count=3.
REQ-037 Data stall: valid line at 0x04 with dmemREN=1 -> ihit=0, hit_count unchanged; dmemREN=0 -> ihit=1.
REQ-038 Flush mid-FILL: miss on 0x80, flush in cycle 2 -> iREN drops next cycle, no line written, refetch of 0x80 misses again.
REQ-039 Reset mid-FILL with counters non-zero -> state IDLE, counters 0, all fetches miss.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: cache controller states and address field widths.
package cpu_types_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Instructions are word sized, so the low two address bits never select anything.
    localparam int BYTOFF_W = 2;

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_nway_if #(
    parameter int WORD_W = 32
);
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              dmemREN;
    logic              dmemWEN;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and data word with combinational lookup.
module icache_way #(
    parameter int NSETS  = 8,
    parameter int TAG_W  = 27,
    parameter int WORD_W = 32,
    localparam int IDX_W = $clog2(NSETS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    output logic              hit,
    output logic              valid,
    output logic [WORD_W-1:0] rdata,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata
);
    logic [NSETS-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_mem  [NSETS];
    logic [WORD_W-1:0] data_mem [NSETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else if (we) begin
            valid_reg[idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= wdata;
        end
    end

    assign valid = valid_reg[idx];
    assign hit   = valid && (tag_mem[idx] == tag);
    assign rdata = data_mem[idx];

endmodule

// File: rtl/icache_nway.sv
// 1- or 2-way set-associative instruction cache with one-word lines and LRU replacement.
module icache_nway
    import cpu_types_pkg::*;
#(
    parameter int NSETS  = 8,
    parameter int NWAYS  = 2,
    parameter int WORD_W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         flush,
    icache_nway_if.slave bus,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = WORD_W - BYTOFF_W - IDX_W;

    icache_state_t     state_reg, state_next;
    logic [WORD_W-1:0] miss_addr_reg;
    logic [NSETS-1:0]  lru_reg;

    logic [WORD_W-1:0] look_addr;
    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic [NWAYS-1:0]  way_hit, way_valid, way_we;
    logic [WORD_W-1:0] way_data [NWAYS];
    logic [WORD_W-1:0] load_sel;
    logic              any_hit, hit_way, victim;
    logic              fetch_ok, ihit_int, miss_start, fill_done;

    // During FILL the single lookup port is steered to the miss line so the
    // victim choice and the write both see the set being filled.
    assign look_addr = (state_reg == FILL) ? miss_addr_reg : bus.imemaddr;
    assign look_idx  = look_addr[BYTOFF_W +: IDX_W];
    assign look_tag  = look_addr[WORD_W-1 -: TAG_W];

    generate
        for (genvar gi = 0; gi < NWAYS; gi++) begin : g_way
            icache_way #(
                .NSETS  (NSETS),
                .TAG_W  (TAG_W),
                .WORD_W (WORD_W)
            ) u_way (
                .CLK   (CLK),
                .nRST  (nRST),
                .flush (flush),
                .idx   (look_idx),
                .tag   (look_tag),
                .hit   (way_hit[gi]),
                .valid (way_valid[gi]),
                .rdata (way_data[gi]),
                .we    (way_we[gi]),
                .wdata (bus.iload)
            );
            assign way_we[gi] = fill_done && (victim == 1'(gi));
        end
    endgenerate

    always_comb begin
        any_hit  = 1'b0;
        hit_way  = 1'b0;
        load_sel = '0;
        victim   = (NWAYS == 1) ? 1'b0 : lru_reg[look_idx];
        for (int w = 0; w < NWAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_way  = 1'(w);
                load_sel = way_data[w];
            end
        end
        // Walk downwards so the lowest-numbered invalid way wins.
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = 1'(w);
            end
        end
    end

    assign fetch_ok     = bus.imemREN && !bus.dmemREN && !bus.dmemWEN && !flush;
    assign ihit_int     = fetch_ok && (state_reg == IDLE) && any_hit;
    assign bus.ihit     = ihit_int;
    assign bus.imemload = load_sel;
    assign bus.iREN     = (state_reg == FILL);
    assign bus.iaddr    = (state_reg == FILL) ? miss_addr_reg : '0;

    always_comb begin
        state_next = state_reg;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fetch_ok && !any_hit) begin
                    miss_start = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!bus.iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
            lru_reg       <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                miss_addr_reg <= {bus.imemaddr[WORD_W-1:BYTOFF_W], {BYTOFF_W{1'b0}}};
            end
            if (ihit_int) begin
                lru_reg[look_idx] <= ~hit_way;
            end else if (fill_done) begin
                lru_reg[look_idx] <= ~victim;
            end
            if (ihit_int && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: directed scenarios plus random fetches against a recency-list cache model.
module tb_icache_nway;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic nRST;

    // index 0: NSETS=8 NWAYS=2, index 1: NSETS=8 NWAYS=1
    logic        imren [2];
    logic        dren  [2];
    logic        dwen  [2];
    logic        flsh  [2];
    logic        iwt   [2];
    logic [31:0] imaddr[2];
    logic        ihit_o[2];
    logic        iren_o[2];
    logic [31:0] iaddr_o[2];
    logic [31:0] load_o[2];
    logic [31:0] hitc[2];
    logic [31:0] missc[2];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    icache_nway_if #(.WORD_W(32)) b0 ();
    icache_nway_if #(.WORD_W(32)) b1 ();

    assign b0.imemREN  = imren[0];
    assign b0.imemaddr = imaddr[0];
    assign b0.dmemREN  = dren[0];
    assign b0.dmemWEN  = dwen[0];
    assign b0.iwait    = iwt[0];
    assign b0.iload    = mem_f(b0.iaddr);
    assign ihit_o[0]   = b0.ihit;
    assign iren_o[0]   = b0.iREN;
    assign iaddr_o[0]  = b0.iaddr;
    assign load_o[0]   = b0.imemload;

    assign b1.imemREN  = imren[1];
    assign b1.imemaddr = imaddr[1];
    assign b1.dmemREN  = dren[1];
    assign b1.dmemWEN  = dwen[1];
    assign b1.iwait    = iwt[1];
    assign b1.iload    = mem_f(b1.iaddr);
    assign ihit_o[1]   = b1.ihit;
    assign iren_o[1]   = b1.iREN;
    assign iaddr_o[1]  = b1.iaddr;
    assign load_o[1]   = b1.imemload;

    icache_nway #(.NSETS(8), .NWAYS(2), .WORD_W(32)) dut2 (
        .CLK(CLK), .nRST(nRST), .flush(flsh[0]), .bus(b0.slave),
        .hit_count(hitc[0]), .miss_count(missc[0])
    );

    icache_nway #(.NSETS(8), .NWAYS(1), .WORD_W(32)) dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flsh[1]), .bus(b1.slave),
        .hit_count(hitc[1]), .miss_count(missc[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per set, resident tags ordered most-recent first.
    logic [26:0] rl [2][8][2];
    int          rc [2][8];
    int          cap[2] = '{2, 1};
    logic [31:0] exp_hit [2];
    logic [31:0] exp_miss[2];

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear(input int d);
        for (int s = 0; s < 8; s++) rc[d][s] = 0;
    endtask

    function automatic bit model_hit(input int d, input logic [31:0] a);
        int s = int'(a[4:2]);
        for (int k = 0; k < rc[d][s]; k++)
            if (rl[d][s][k] == a[31:5]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_touch(input int d, input logic [31:0] a);
        int s = int'(a[4:2]);
        logic [26:0] old [2];
        int n = rc[d][s];
        int k = 1;
        old = rl[d][s];
        rl[d][s][0] = a[31:5];
        for (int j = 0; j < n; j++) begin
            if (old[j] != a[31:5] && k < cap[d]) begin
                rl[d][s][k] = old[j];
                k++;
            end
        end
        rc[d][s] = k;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic check_counters(input int d);
        check($sformatf("hit_count[%0d]", d), hitc[d], exp_hit[d]);
        check($sformatf("miss_count[%0d]", d), missc[d], exp_miss[d]);
    endtask

    // Fetch one address; lat = cycles of iwait=1 before the memory answers.
    task automatic fetch(input int d, input logic [31:0] a, input int lat);
        bit h = model_hit(d, a);
        imren[d] = 1'b1; imaddr[d] = a; iwt[d] = (lat > 0); #1;
        check("ihit_first", 32'(ihit_o[d]), 32'(h));
        if (!h) begin
            exp_miss[d] = sat_inc(exp_miss[d]);
            step();
            for (int c = 0; c <= lat; c++) begin
                iwt[d] = (c < lat); #1;
                check("fill_iren", 32'(iren_o[d]), 32'd1);
                check("fill_iaddr", iaddr_o[d], {a[31:2], 2'b00});
                check("fill_ihit", 32'(ihit_o[d]), 32'd0);
                step();
            end
            #1;
            check("post_fill_ihit", 32'(ihit_o[d]), 32'd1);
            check("post_fill_iren", 32'(iren_o[d]), 32'd0);
        end
        check("imemload", load_o[d], mem_f({a[31:2], 2'b00}));
        model_touch(d, a);
        exp_hit[d] = sat_inc(exp_hit[d]);
        step();
        imren[d] = 1'b0; #1;
        check_counters(d);
        $display("fetch dut%0d addr=%08h lat=%0d expect_%s", d, a, lat, h ? "hit" : "miss");
    endtask

    // One-cycle flush while a fetch of a is presented: ihit must be suppressed.
    task automatic flush_cache(input int d, input logic [31:0] a);
        imren[d] = 1'b1; imaddr[d] = a; flsh[d] = 1'b1; #1;
        check("flush_ihit", 32'(ihit_o[d]), 32'd0);
        step();
        flsh[d] = 1'b0; imren[d] = 1'b0;
        model_clear(d);
        #1;
        check_counters(d);
        $display("flush dut%0d", d);
    endtask

    initial begin
        nRST = 1'b0;
        for (int d = 0; d < 2; d++) begin
            imren[d] = 0; dren[d] = 0; dwen[d] = 0; flsh[d] = 0; iwt[d] = 0;
            imaddr[d] = '0; exp_hit[d] = '0; exp_miss[d] = '0;
            model_clear(d);
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ihit", 32'(ihit_o[d]), 32'd0);
            check("rst_iren", 32'(iren_o[d]), 32'd0);
            check("rst_iaddr", iaddr_o[d], 32'd0);
            check_counters(d);
        end
        nRST = 1'b1;
        step();

        // Cold miss with three wait cycles
        fetch(0, 32'h0000_0040, 3);
        check("cold_miss_count", missc[0], 32'd1);
        check("cold_hit_count", hitc[0], 32'd1);

        // Conflict in set 0: 0x40 evicts the LRU line 0x20
        flush_cache(0, 32'h0000_0040);
        fetch(0, 32'h0000_0000, 1);
        fetch(0, 32'h0000_0020, 0);
        fetch(0, 32'h0000_0000, 0);
        fetch(0, 32'h0000_0040, 2);
        fetch(0, 32'h0000_0000, 0);
        fetch(0, 32'h0000_0020, 1);
        check("conflict_miss_count", missc[0], 32'd5);

        // Direct-mapped: every access to set 0 misses
        fetch(1, 32'h0000_0000, 0);
        fetch(1, 32'h0000_0020, 1);
        fetch(1, 32'h0000_0000, 0);
        check("dm_miss_count", missc[1], 32'd3);

        // Data access in progress suppresses ihit
        fetch(0, 32'h0000_0004, 0);
        imren[0] = 1'b1; imaddr[0] = 32'h0000_0004; dren[0] = 1'b1; #1;
        check("stall_ihit", 32'(ihit_o[0]), 32'd0);
        step();
        check("stall_hit_count", hitc[0], exp_hit[0]);
        check("stall_iren", 32'(iren_o[0]), 32'd0);
        dren[0] = 1'b0; #1;
        check("unstall_ihit", 32'(ihit_o[0]), 32'd1);
        model_touch(0, 32'h0000_0004);
        exp_hit[0] = sat_inc(exp_hit[0]);
        step();
        imren[0] = 1'b0; #1;
        check_counters(0);
        $display("data stall dut0 addr=00000004");

        // Flush in the second fill cycle aborts the fill even with data ready
        imren[0] = 1'b1; imaddr[0] = 32'h0000_0080; iwt[0] = 1'b1; #1;
        check("fm_ihit", 32'(ihit_o[0]), 32'd0);
        exp_miss[0] = sat_inc(exp_miss[0]);
        step();
        check("fm_iren1", 32'(iren_o[0]), 32'd1);
        step();
        flsh[0] = 1'b1; iwt[0] = 1'b0; #1;
        check("fm_iren2", 32'(iren_o[0]), 32'd1);
        step();
        flsh[0] = 1'b0; imren[0] = 1'b0; #1;
        check("fm_iren_after", 32'(iren_o[0]), 32'd0);
        model_clear(0);
        check_counters(0);
        $display("flush mid-fill dut0 addr=00000080");
        fetch(0, 32'h0000_0080, 1);

        // Random fetches over 32 addresses (4 tags x 8 sets) with random latency
        for (int i = 0; i < 300; i++) begin
            int d = i % 2;
            logic [31:0] a;
            a = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 15) == 0) flush_cache(d, a);
            fetch(d, a, int'($urandom_range(0, 3)));
        end

        // Reset during a fill: counters cleared, no line kept
        fetch(0, 32'h0000_0004, 0);
        imren[0] = 1'b1; imaddr[0] = 32'h0000_0048; iwt[0] = 1'b1; #1;
        step();
        check("rf_iren", 32'(iren_o[0]), 32'd1);
        nRST = 1'b0; #1;
        check("rf_iren_rst", 32'(iren_o[0]), 32'd0);
        check("rf_iaddr_rst", iaddr_o[0], 32'd0);
        check("rf_hit_rst", hitc[0], 32'd0);
        check("rf_miss_rst", missc[0], 32'd0);
        step();
        nRST = 1'b1; imren[0] = 1'b0; iwt[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            exp_hit[d] = '0;
            exp_miss[d] = '0;
        end
        step();
        $display("reset mid-fill dut0 addr=00000048");
        fetch(0, 32'h0000_0048, 0);
        fetch(0, 32'h0000_0004, 1);
        check("rf_refetch_miss", missc[0], 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
